// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage between execute and write-back
//
// Ports:
//   clk, resetn        pipeline clock (rising edge), asynchronous active-low reset
//   es_to_ms_valid     execute holds a valid instruction
//   es_to_ms_bus[74:0] {ld_type[2:0], res_from_mem, mem_req, gr_we, dest[4:0], alu_result[31:0], pc[31:0]}
//   ms_allowin         stage can accept a new instruction this cycle
//   ws_allowin         write-back can accept
//   ms_to_ws_valid     payload valid toward write-back
//   ms_to_ws_bus[69:0] {gr_we, dest[4:0], final_result[31:0], pc[31:0]}
//   ms_fwd_blk_bus[38:0] {rf_wen, rf_dest[4:0], blk, fwd_data[31:0]} toward decode
//   data_sram_data_ok  one-cycle response strobe from data SRAM
//   data_sram_rdata    read data, valid while data_ok is high

module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        es_to_ms_valid,
    input  logic [74:0] es_to_ms_bus,
    output logic        ms_allowin,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    output logic [38:0] ms_fwd_blk_bus,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata
);

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    logic        ms_valid;
    logic [74:0] bus_r;
    logic        resp_got;
    logic [31:0] rdata_buf;

    logic [2:0]  ld_type;
    logic        res_from_mem;
    logic        mem_req;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    assign ld_type      = bus_r[74:72];
    assign res_from_mem = bus_r[71];
    assign mem_req      = bus_r[70];
    assign gr_we        = bus_r[69];
    assign dest         = bus_r[68:64];
    assign alu_result   = bus_r[63:32];
    assign pc           = bus_r[31:0];

    logic ms_ready_go;
    logic resp_accept;
    logic latch_new;

    assign ms_ready_go    = !mem_req || resp_got || data_sram_data_ok;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign latch_new      = es_to_ms_valid && ms_allowin;
    // Only the first response for the resident instruction counts; strays are dropped.
    assign resp_accept    = ms_valid && mem_req && !resp_got && data_sram_data_ok;

    // Once captured, the buffer overrides the live bus so the output stays stable under stall.
    logic [31:0] mem_word;
    logic [1:0]  off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] extracted;
    logic [31:0] final_result;

    assign mem_word = resp_got ? rdata_buf : data_sram_rdata;
    assign off      = alu_result[1:0];
    assign half_sel = off[1] ? mem_word[31:16] : mem_word[15:0];

    always_comb begin
        byte_sel = mem_word[7:0];
        case (off)
            2'd0: byte_sel = mem_word[7:0];
            2'd1: byte_sel = mem_word[15:8];
            2'd2: byte_sel = mem_word[23:16];
            2'd3: byte_sel = mem_word[31:24];
            default: byte_sel = mem_word[7:0];
        endcase
    end

    always_comb begin
        extracted = mem_word;
        case (ld_type)
            LD_W:  extracted = mem_word;
            LD_B:  extracted = {{24{byte_sel[7]}}, byte_sel};
            LD_BU: extracted = {24'd0, byte_sel};
            LD_H:  extracted = {{16{half_sel[15]}}, half_sel};
            LD_HU: extracted = {16'd0, half_sel};
            default: extracted = mem_word;
        endcase
    end

    assign final_result = res_from_mem ? extracted : alu_result;

    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

    logic rf_wen;
    logic blk;

    assign rf_wen = ms_valid && gr_we;
    assign blk    = ms_valid && gr_we && res_from_mem && !ms_ready_go;
    assign ms_fwd_blk_bus = {rf_wen, dest, blk, final_result};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid  <= 1'b0;
            bus_r     <= '0;
            resp_got  <= 1'b0;
            rdata_buf <= '0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (latch_new) begin
                bus_r    <= es_to_ms_bus;
                resp_got <= 1'b0;
            end else if (resp_accept && !ws_allowin) begin
                // Response arrived but write-back is stalled: hold it until we can leave.
                resp_got  <= 1'b1;
                rdata_buf <= data_sram_rdata;
            end
        end
    end

endmodule
